softplus_rr_scheduler: RTL and testbench
========================================

# softplus_rr_scheduler

Round-robin scheduler that shares one fixed-latency piecewise-linear activation unit (the 8-slice softplus pipeline, Q-format BITSIZE-bit) between NREQ requesters. Accepts samples from requesters over valid/ready and issues at most one sample per cycle into the unit. Tracks each in-flight sample's owner through a tag pipeline matched to the unit latency, and returns each result to its owner as a one-cycle valid pulse. Sits between the layer-level neuron controllers and the single shared activation instance.

## Interface
- BITSIZE, 16, sample/result width (fixed-point, same format as the activation unit)
- NREQ, 4, number of requesters (2..8)
- LAT, 3, activation unit latency in clock edges, act_in to act_out
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- en  in  1  grant enable; low = no new issues, in-flight samples still drain
- req_valid  in  NREQ  per-requester sample valid
- req_data  in  NREQ*BITSIZE  per-requester sample, requester i at bits [i*BITSIZE +: BITSIZE]
- req_ready  out  NREQ  one-hot grant (or zero); handshake when valid&ready at an edge
- act_in  out  BITSIZE  registered sample to activation unit data_in
- act_out  in  BITSIZE  activation unit data_out
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_data belongs to requester i
- rsp_data  out  BITSIZE  registered result, shared by all requesters
- busy  out  1  high while any sample is issued but not yet returned

## Operation
- Arbitration: combinational; among i with req_valid[i], grant the first at or after rr_ptr, wrapping modulo NREQ. req_ready = that one-hot when en=1, else 0. req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- rr_ptr: register, advances to (granted index + 1) mod NREQ on each handshake; unchanged otherwise.
- Issue: on handshake, act_in <= granted req_data, and tag stage 0 <= {valid=1, id=granted index}. No handshake: act_in holds its value, tag stage 0 valid=0.
- Tag pipeline: LAT stages of {valid, id (clog2(NREQ) bits)}, shifting every cycle unconditionally; no stall, the unit has no backpressure.
- Return: when final tag stage valid, rsp_data <= act_out, rsp_valid <= onehot(id); else rsp_valid <= 0, rsp_data holds.
- No response backpressure: requesters must consume rsp_valid pulses when they occur.
- busy = OR of all tag valid bits (combinational from registers).
- en low mid-stream: issuing stops next edge; pipeline drains, busy falls after last return.
- Arithmetic: scheduler does no arithmetic on data; values pass bit-exact.

## Timing
- Reset (reset=0 at an edge): act_in=0, rsp_data=0, rsp_valid=0, rr_ptr=0, all tag valid=0, hence busy=0 and req_ready=0 during reset.
- Reset mid-operation: all in-flight samples discarded, no rsp_valid for them; the activation unit may still emit stale act_out, ignored because tags are cleared.
- Latency: handshake at edge E -> act_in valid after E -> rsp_valid/rsp_data valid after edge E+LAT+1 (default 4 cycles), high for exactly one cycle.
- Throughput: one issue per cycle; back-to-back handshakes give back-to-back responses in issue order.
- A single requester held valid is granted every cycle (fairness only applies under contention).
- Contention: with k requesters continuously valid, each granted once per k cycles.
- Simultaneous issue and return in same cycle is normal operation, no conflict.

## Structure
- Shared package softplus_sched_pkg: default LAT, NREQ, BITSIZE, ID width function (clog2), tag struct/field widths.
- One sub-module: rr_arbiter (NREQ-wide round-robin request/grant with pointer register, en input, grant one-hot and index outputs). Tag pipeline and response register stay in the top.
- Activation unit instantiated outside; scheduler connects through act_in/act_out only.

## Test plan
- Reset: hold reset=0 two cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0, act_in=0; release -> first grant to requester 0.
- Single requester: requester 2 sends 0x0100 at edge E -> rsp_valid=4'b0100 after edge E+4 with rsp_data equal to the unit's output for 0x0100; busy high from E to E+3, low after.
- Full contention: all four valid continuously, distinct data -> grants 0,1,2,3,0,1... one per cycle; responses arrive 4 cycles later in the same id order, data bit-exact to unit output.
- Pointer wrap: rr_ptr=3, requesters 0 and 3 valid -> grant 3, then 0; requesters 1,2 idle never granted.
- en low mid-stream: drop en after 3 issues -> req_ready=0 next cycle, exactly 3 rsp pulses still delivered, busy falls after last.
- Reset mid-operation: assert reset with 3 samples in flight -> no rsp_valid pulses for them afterward, rr_ptr=0, busy=0.

Source files
------------

// File: rtl/softplus_sched_pkg.sv
// Shared defaults and tag type for the softplus round-robin scheduler.
package softplus_sched_pkg;

  localparam int DEF_BITSIZE = 16;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_LAT     = 3;
  localparam int MAX_NREQ    = 8;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int idWidth(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Tag ids are sized for the largest supported requester count so one
  // struct type serves every NREQ instance.
  localparam int TAG_ID_W = idWidth(MAX_NREQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/softplus_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active requester at or after a
// rotating pointer, which moves just past each granted requester.
module rr_arbiter
  import softplus_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [NREQ-1:0]          req_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [idWidth(NREQ)-1:0] gntIdx_o,
  output logic                     gntValid_o
);

  localparam int IDW = idWidth(NREQ);

  logic [IDW-1:0] rrPtr_q, rrPtr_d;
  logic [IDW:0]   candIdx;
  logic [IDW-1:0] pickIdx;
  logic           found;

  // Scan forward from the pointer with wrap-around for the first request
  always_comb begin
    found   = 1'b0;
    pickIdx = '0;
    candIdx = '0;
    for (int off = 0; off < NREQ; off++) begin
      candIdx = {1'b0, rrPtr_q} + (IDW+1)'(off);
      if (candIdx >= (IDW+1)'(NREQ)) begin
        candIdx = candIdx - (IDW+1)'(NREQ);
      end
      if (!found && req_i[candIdx[IDW-1:0]]) begin
        found   = 1'b1;
        pickIdx = candIdx[IDW-1:0];
      end
    end
  end

  // Gate the grant with enable and reset, and compute the next pointer
  always_comb begin
    gntValid_o = found & en_i & reset_i;
    gntIdx_o   = pickIdx;
    gnt_o      = gntValid_o ? (NREQ'(1) << pickIdx) : '0;
    rrPtr_d    = rrPtr_q;
    if (gntValid_o) begin
      rrPtr_d = (pickIdx == IDW'(NREQ - 1)) ? '0 : pickIdx + IDW'(1);
    end
  end

  // Pointer register, cleared by the active-low synchronous reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/softplus_rr_scheduler.sv
// Shares one fixed-latency activation unit between NREQ requesters. A tag
// pipeline tracks each sample's owner so the result returns to that owner.
module softplus_rr_scheduler
  import softplus_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int NREQ    = DEF_NREQ,
  parameter int LAT     = DEF_LAT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*BITSIZE-1:0] req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [BITSIZE-1:0]      act_in_o,
  input  logic [BITSIZE-1:0]      act_out_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic [BITSIZE-1:0]      rsp_data_o,
  output logic                    busy_o
);

  localparam int IDW = idWidth(NREQ);

  logic [NREQ-1:0]              gnt;
  logic [IDW-1:0]               gntIdx;
  logic                         gntValid;
  logic [NREQ-1:0][BITSIZE-1:0] reqData;
  logic [BITSIZE-1:0]           actIn_q, actIn_d;
  logic [BITSIZE-1:0]           rspData_q, rspData_d;
  logic [NREQ-1:0]              rspValid_q, rspValid_d;
  tag_t                         tagIn_d;
  tag_t                         tagLast;

  // Stage 0 travels alongside act_in; stages 1..LAT mirror the unit's
  // latency, so stage LAT lines up with act_out for that sample.
  tag_t tagPipe_q [LAT+1];

  rr_arbiter #(
    .NREQ(NREQ)
  ) uArbiter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .req_i     (req_valid_i),
    .gnt_o     (gnt),
    .gntIdx_o  (gntIdx),
    .gntValid_o(gntValid)
  );

  assign reqData     = req_data_i;
  assign req_ready_o = gnt;
  assign tagLast     = tagPipe_q[LAT];

  // Select the granted sample and build the tag for the new issue
  always_comb begin
    actIn_d = actIn_q;
    tagIn_d = '0;
    if (gntValid) begin
      actIn_d       = reqData[gntIdx];
      tagIn_d.valid = 1'b1;
      tagIn_d.id    = TAG_ID_W'(gntIdx);
    end
  end

  // Issue register and tag shift; the unit never stalls so neither do we
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      actIn_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tagPipe_q[i] <= '0;
      end
    end else begin
      actIn_q      <= actIn_d;
      tagPipe_q[0] <= tagIn_d;
      for (int i = 1; i <= LAT; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  // Route the unit output back to the owner named by the oldest tag
  always_comb begin
    rspValid_d = '0;
    rspData_d  = rspData_q;
    if (tagLast.valid) begin
      rspValid_d = NREQ'(1) << tagLast.id;
      rspData_d  = act_out_i;
    end
  end

  // Response register; reset drops any result still on its way back
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rspValid_q <= '0;
      rspData_q  <= '0;
    end else begin
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

  // Busy while any tag stage still holds an issued sample
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      busy_o = busy_o | tagPipe_q[i].valid;
    end
  end

  assign act_in_o    = actIn_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_data_o  = rspData_q;

endmodule

// File: tb/tb_softplus_rr_scheduler.sv
// Testbench for softplus_rr_scheduler with a stand-in activation unit and a
// queue-based model of issue order, ownership and return timing.
module tb_softplus_rr_scheduler;

  localparam int BITSIZE = 16;
  localparam int NREQ    = 4;
  localparam int LAT     = 3;

  typedef struct {
    int                 retCycle;
    int                 id;
    logic [BITSIZE-1:0] data;
  } flight_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    en = 1'b0;
  logic [NREQ-1:0]         reqValid = '0;
  logic [NREQ*BITSIZE-1:0] reqData = '0;
  logic [NREQ-1:0]         reqReady;
  logic [BITSIZE-1:0]      actIn;
  logic [BITSIZE-1:0]      actOut;
  logic [NREQ-1:0]         rspValid;
  logic [BITSIZE-1:0]      rspData;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  bit armed = 1'b0;

  flight_t            inflight[$];
  int                 modelPtr = 0;
  logic [BITSIZE-1:0] modelActIn = '0;
  logic [BITSIZE-1:0] modelRspData = '0;
  logic [NREQ-1:0]    expValid;
  logic [NREQ-1:0]    expReady;
  int                 pick;
  int                 pulseCount;

  logic [BITSIZE-1:0] actPipe [LAT];

  softplus_rr_scheduler #(
    .BITSIZE(BITSIZE),
    .NREQ   (NREQ),
    .LAT    (LAT)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .req_valid_i(reqValid),
    .req_data_i (reqData),
    .req_ready_o(reqReady),
    .act_in_o   (actIn),
    .act_out_i  (actOut),
    .rsp_valid_o(rspValid),
    .rsp_data_o (rspData),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Stand-in activation transfer: byte swap then invert the low byte
  function automatic logic [BITSIZE-1:0] actFn(input logic [BITSIZE-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h00FF;
  endfunction

  // Fixed-latency activation unit, LAT edges from act_in to act_out
  always @(posedge clk) begin
    actPipe[0] <= actFn(actIn);
    for (int k = 1; k < LAT; k++) actPipe[k] <= actPipe[k-1];
  end
  assign actOut = actPipe[LAT-1];

  // Edge counter used to time model responses
  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)",
               name, actual, expected, edgeCount);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic enV,
                               input logic [NREQ-1:0] v,
                               input logic [NREQ*BITSIZE-1:0] d);
    @(posedge clk);
    #1;
    reset    = rstN;
    en       = enV;
    reqValid = v;
    reqData  = d;
  endtask

  // Per-cycle comparison of every output against the behavioural model
  always @(negedge clk) begin
    if (armed) begin
      expValid = '0;
      if (inflight.size() > 0 && inflight[0].retCycle == edgeCount) begin
        expValid[inflight[0].id] = 1'b1;
        modelRspData = actFn(inflight[0].data);
        void'(inflight.pop_front());
      end
      checkOutput("rsp_valid", 32'(rspValid), 32'(expValid));
      checkOutput("rsp_data", 32'(rspData), 32'(modelRspData));
      checkOutput("busy", 32'(busy), 32'(inflight.size() != 0));
      checkOutput("act_in", 32'(actIn), 32'(modelActIn));

      expReady = '0;
      pick = -1;
      if (reset && en) begin
        for (int k = 0; k < NREQ; k++) begin
          if (pick < 0 && reqValid[(modelPtr + k) % NREQ]) pick = (modelPtr + k) % NREQ;
        end
      end
      if (pick >= 0) expReady[pick] = 1'b1;
      checkOutput("req_ready", 32'(reqReady), 32'(expReady));

      if (!reset) begin
        inflight.delete();
        modelPtr     = 0;
        modelActIn   = '0;
        modelRspData = '0;
      end else if (pick >= 0) begin
        inflight.push_back('{retCycle: edgeCount + LAT + 2, id: pick,
                             data: reqData[pick*BITSIZE +: BITSIZE]});
        modelActIn = reqData[pick*BITSIZE +: BITSIZE];
        modelPtr   = (pick + 1) % NREQ;
      end
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic
  initial begin
    logic [NREQ*BITSIZE-1:0] contData;
    contData = {16'hD004, 16'hC003, 16'hB002, 16'hA001};

    $display("[TB] reset with all requesters valid");
    applyStimulus(1'b0, 1'b1, 4'hF, contData);
    applyStimulus(1'b0, 1'b1, 4'hF, contData);
    armed = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(reqReady), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_act_in", 32'(actIn), 32'h0);

    $display("[TB] release into full contention");
    applyStimulus(1'b1, 1'b1, 4'hF, contData);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("contention_grant", 32'(reqReady), 32'(1 << (k % 4)));
      if (k == 5) begin
        checkOutput("contention_rsp0_valid", 32'(rspValid), 32'h1);
        checkOutput("contention_rsp0_data", 32'(rspData), 32'h015F);
      end
      if (k == 6) begin
        checkOutput("contention_rsp1_valid", 32'(rspValid), 32'h2);
        checkOutput("contention_rsp1_data", 32'(rspData), 32'h024F);
      end
    end
    applyStimulus(1'b1, 1'b1, 4'h0, '0);
    repeat (8) @(negedge clk);

    $display("[TB] single requester latency");
    applyStimulus(1'b1, 1'b1, 4'b0100, 64'h0000_0100_0000_0000);
    @(negedge clk);
    checkOutput("single_ready", 32'(reqReady), 32'h4);
    applyStimulus(1'b1, 1'b1, 4'h0, '0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("single_act_in", 32'(actIn), 32'h0100);
      if (k < 4) begin
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_no_rsp", 32'(rspValid), 32'h0);
      end else begin
        checkOutput("single_busy_low", 32'(busy), 32'h0);
        checkOutput("single_rsp_valid", 32'(rspValid), 32'h4);
        checkOutput("single_rsp_data", 32'(rspData), 32'h00FE);
      end
    end

    $display("[TB] pointer wrap from 3");
    applyStimulus(1'b1, 1'b1, 4'b1001, contData);
    @(negedge clk);
    checkOutput("wrap_grant3", 32'(reqReady), 32'h8);
    @(negedge clk);
    checkOutput("wrap_grant0", 32'(reqReady), 32'h1);
    @(negedge clk);
    checkOutput("wrap_grant3_again", 32'(reqReady), 32'h8);
    applyStimulus(1'b1, 1'b1, 4'h0, '0);
    repeat (8) @(negedge clk);

    $display("[TB] enable dropped after three issues");
    repeat (3) applyStimulus(1'b1, 1'b1, 4'hF, contData);
    applyStimulus(1'b1, 1'b0, 4'hF, contData);
    @(negedge clk);
    checkOutput("en_low_ready", 32'(reqReady), 32'h0);
    pulseCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (rspValid != '0) pulseCount++;
    end
    checkOutput("en_low_pulses", 32'(pulseCount), 32'd3);
    checkOutput("en_low_busy_end", 32'(busy), 32'h0);

    $display("[TB] reset with samples in flight");
    repeat (3) applyStimulus(1'b1, 1'b1, 4'hF, contData);
    applyStimulus(1'b0, 1'b1, 4'hF, contData);
    @(negedge clk);
    checkOutput("midreset_busy_before", 32'(busy), 32'h1);
    checkOutput("midreset_ready", 32'(reqReady), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, '0);
    pulseCount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("midreset_busy_after", 32'(busy), 32'h0);
      if (rspValid != '0) pulseCount++;
    end
    checkOutput("midreset_pulses", 32'(pulseCount), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'hF, contData);
    @(negedge clk);
    checkOutput("midreset_ptr_zero", 32'(reqReady), 32'h1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                    NREQ'($urandom), {$urandom, $urandom});
    end
    applyStimulus(1'b1, 1'b1, 4'h0, '0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
